// File: rtl/golf_input_conditioner.sv
// Button front end for the golf gameplay FSM: sync + debounce, pan arbitration, frame strobe, shot arming.
// Define DEBOUNCE_BYPASS_EN to replace the debouncers with the bare 2-FF synchronizers.
module golf_input_conditioner #(
  parameter int DEBOUNCE_CYCLES   = 500_000,
  parameter int FRAME_CYCLES      = 1_666_667,
  parameter int MIN_CHARGE_FRAMES = 2
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       btn_hit_in,
  input  logic       btn_left_in,
  input  logic       btn_right_in,
  input  logic [2:0] gameplay_state_in,
  output logic       charging_hit,
  output logic       camera_pan_left,
  output logic       camera_pan_right,
  output logic       new_frame
);

  localparam int FR_W = $clog2(FRAME_CYCLES + 1);
  localparam int FC_W = $clog2(MIN_CHARGE_FRAMES + 1);
  localparam logic [FR_W-1:0] FR_LAST = FR_W'(FRAME_CYCLES - 1);
  localparam logic [FC_W-1:0] CHG_MIN = FC_W'(MIN_CHARGE_FRAMES);

  typedef enum logic [2:0] {WAIT_REST, LOCKOUT, READY, CHARGE, FIRED} state_t;

  // lane 0 = hit, 1 = pan left, 2 = pan right
  logic [2:0] w_raw, r_sync1, r_sync2, w_deb;
  assign w_raw = {btn_right_in, btn_left_in, btn_hit_in};

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_db
`ifdef DEBOUNCE_BYPASS_EN
    assign w_deb[g] = r_sync2[g];
`else
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    logic [DB_W-1:0] r_cnt;
    logic            r_lvl;
    always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
        r_cnt <= '0;
        r_lvl <= 1'b0;
      end else if (r_sync2[g] == r_lvl) begin
        r_cnt <= '0;
      end else if (r_cnt == DB_LAST) begin
        r_lvl <= r_sync2[g];
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + DB_W'(1);
      end
    end
    assign w_deb[g] = r_lvl;
`endif
  end

  logic r_pan_l, r_pan_r;
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_pan_l <= 1'b0;
      r_pan_r <= 1'b0;
    end else begin
      r_pan_l <= w_deb[1] & ~w_deb[2];
      r_pan_r <= w_deb[2] & ~w_deb[1];
    end
  end

  logic [FR_W-1:0] r_frm_cnt;
  logic            r_new_frame;
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_frm_cnt   <= '0;
      r_new_frame <= 1'b0;
    end else begin
      r_frm_cnt   <= (r_frm_cnt == FR_LAST) ? '0 : r_frm_cnt + FR_W'(1);
      r_new_frame <= (r_frm_cnt == FR_LAST);
    end
  end

  state_t          r_state, w_state_nxt;
  logic            r_hit_prev, w_clr_cnt, r_chg;
  logic [FC_W-1:0] r_chg_cnt;
  logic            w_hit, w_st_rest, w_st_other;
  assign w_hit      = w_deb[0];
  assign w_st_rest  = (gameplay_state_in == 3'd0);
  assign w_st_other = (gameplay_state_in > 3'd1);

  always_comb begin
    w_state_nxt = r_state;
    w_clr_cnt   = 1'b0;
    case (r_state)
      WAIT_REST: if (w_st_rest) w_state_nxt = w_hit ? LOCKOUT : READY;
      LOCKOUT: begin
        if (!w_st_rest)  w_state_nxt = WAIT_REST;
        else if (!w_hit) w_state_nxt = READY;
      end
      // a state change outranks a simultaneous press
      READY: begin
        if (!w_st_rest) begin
          w_state_nxt = WAIT_REST;
        end else if (w_hit && !r_hit_prev) begin
          w_state_nxt = CHARGE;
          w_clr_cnt   = 1'b1;
        end
      end
      CHARGE: begin
        if (w_st_other)                          w_state_nxt = WAIT_REST;
        else if (!w_hit && r_chg_cnt >= CHG_MIN) w_state_nxt = FIRED;
      end
      FIRED:   if (w_st_other) w_state_nxt = WAIT_REST;
      default: w_state_nxt = WAIT_REST;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state    <= WAIT_REST;
      r_hit_prev <= 1'b0;
      r_chg      <= 1'b0;
      r_chg_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hit_prev <= w_hit;
      r_chg      <= (w_state_nxt == CHARGE);
      if (w_clr_cnt)
        r_chg_cnt <= '0;
      else if (r_state == CHARGE && r_new_frame && r_chg_cnt != CHG_MIN)
        r_chg_cnt <= r_chg_cnt + FC_W'(1);
    end
  end

  assign charging_hit     = r_chg;
  assign camera_pan_left  = r_pan_l;
  assign camera_pan_right = r_pan_r;
  assign new_frame        = r_new_frame;

endmodule
